chara_feeder: RTL and testbench
===============================

CHARA_FEEDER -- requirements
Module: chara_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the byte FIFO depth; the value SHALL be a power of two and at least 2.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port EN, input, 1 bit: global enable, shared with the matcher.
REQ-005 The block SHALL have port BYTE_IN, input, 8 bits: the text byte.
REQ-006 The block SHALL have port BYTE_LAST, input, 1 bit: BYTE_IN is the final byte of the text.
REQ-007 The block SHALL have port BYTE_VALID, input, 1 bit: the byte source offers BYTE_IN.
REQ-008 The block SHALL have port BYTE_READY, output, 1 bit: the block accepts a byte this cycle.
REQ-009 The block SHALL have port CHARA, output, 4 bits: the alphabet symbol presented to the goto/failure lookup.
REQ-010 The block SHALL have port CHARA_VALID, output, 1 bit: CHARA is valid.
REQ-011 The block SHALL have port CHARA_LAST, output, 1 bit: CHARA is the final symbol of the text.
REQ-012 The block SHALL have port CHARA_READY, input, 1 bit: the matcher consumes CHARA this cycle.

Function
REQ-013 A byte transfer SHALL occur on a rising edge where BYTE_VALID, BYTE_READY and EN are all 1.
REQ-014 BYTE_READY SHALL equal (FIFO not full) AND EN, with no combinational path from CHARA_READY.
REQ-015 Each byte SHALL be stored in the FIFO together with its BYTE_LAST flag.
REQ-016 The output FSM SHALL have three states:
- IDLE: no symbol presented.
- HI: presents BYTE_IN[7:4] of the head byte.
- LO: presents BYTE_IN[3:0] of the head byte.
REQ-017 CHARA_VALID SHALL be 1 exactly in HI and LO.
REQ-018 A symbol transfer SHALL occur on a rising edge where CHARA_VALID, CHARA_READY and EN are all 1.
REQ-019 FSM transitions:
- IDLE to HI when the FIFO is non-empty and EN is 1.
- HI to LO on a symbol transfer.
- LO, on a symbol transfer: pop the head byte, then go to HI if another byte remains, otherwise to IDLE.
REQ-020 CHARA_LAST SHALL be 1 only in LO while the head byte's stored last flag is 1; in HI it SHALL be 0.
REQ-021 While CHARA_VALID is 1 and no transfer has occurred, CHARA and CHARA_LAST SHALL hold stable.
REQ-022 Latency: a byte written into an empty FIFO on edge N SHALL give CHARA_VALID=1 after edge N+1.
REQ-023 Sustained throughput SHALL be one symbol per cycle, i.e. one byte every two cycles.
REQ-024 A push and a pop on the same edge SHALL both take effect and leave the occupancy unchanged.
REQ-025 A full FIFO SHALL refuse a push even when a pop occurs on the same edge; there is no pass-through.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH, and occupancy SHALL be tracked with a log2(DEPTH)+1-bit count.
REQ-027 When EN is 0, no push, pop or FSM transition SHALL occur, and all outputs except BYTE_READY SHALL hold their values.

Reset
REQ-028 RST=1 SHALL asynchronously force:
- FSM to IDLE;
- pointers and count to 0;
- CHARA to 0;
- CHARA_VALID, CHARA_LAST and BYTE_READY to 0.
REQ-029 Reset asserted mid-text SHALL discard all buffered bytes, including a partially sent byte; no symbol SHALL be emitted after release until a new byte is accepted.
REQ-030 The FIFO storage array SHALL need no reset.

Configuration
REQ-031 With macro CHARA_FEEDER_COUNT_EN defined, the block SHALL add output CHARA_CNT (16 bits).
- CHARA_CNT resets to 0 and increments on each symbol transfer.
- It wraps from 0xFFFF to 0.
- It clears to 0 on the edge after a transfer with CHARA_LAST=1.
REQ-032 Without CHARA_FEEDER_COUNT_EN, the port and its counter SHALL be absent, with all other behaviour identical.

Structure
REQ-033 The shared package SHALL hold the FSM state typedef (IDLE/HI/LO), the 4-bit CHARA width and the 8-bit byte width, for reuse by the goto/failure stages.
REQ-034 The FIFO SHALL be one sub-module, chara_fifo, parameterised by DEPTH and a 9-bit data width.

Verification
REQ-035 Directed scenarios the bench SHALL cover:
- Single byte 0xA5 with LAST=1 and CHARA_READY held 1: CHARA 0xA then 0x5 on consecutive cycles, CHARA_LAST=1 only with 0x5, then IDLE.
- Eight bytes pushed with CHARA_READY=0 and DEPTH=8: BYTE_READY=0 after the 8th push; CHARA holds 0x? high nibble of byte 0 stable; releasing READY drains 16 symbols in order.
- Continuous push/pop at half rate, bytes 0x12, 0x34, 0x56: symbol stream 1,2,3,4,5,6; count never exceeds 1; no loss.
- EN dropped for 3 cycles while in LO: CHARA unchanged, no pop, BYTE_READY=0; resumes on the same symbol.
- RST pulsed while in LO with 3 bytes buffered: outputs 0 immediately, the next accepted byte 0xF0 yields 0xF, 0x0.
- With CHARA_FEEDER_COUNT_EN: 0x0000 to 0x0003 over 2 bytes, and 0 after the LAST symbol.

Source files
------------

// File: rtl/chara_feeder_pkg.sv
// Shared definitions for the text-feeding front end of the string matcher.
// Holds the feeder FSM state type and the symbol/byte widths so the
// goto/failure lookup stages can size their ports from the same source.
package chara_feeder_pkg;

  localparam int CHARA_W = 4;            // alphabet symbol width (one nibble)
  localparam int BYTE_W  = 8;            // text byte width
  localparam int ENTRY_W = BYTE_W + 1;   // FIFO entry: {last, byte}

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // nothing presented
    HI   = 2'd1,   // presenting high nibble of head byte
    LO   = 2'd2    // presenting low nibble of head byte
  } feed_state_t;

endpackage

// File: rtl/chara_fifo.sv
// Byte FIFO between the text source and the nibble sequencer.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset (control only)
//   push, wr_data - write request and entry; ignored while full, even if a
//                   pop happens on the same edge (no pass-through)
//   pop           - remove the head entry; ignored while empty
//   rd_data       - head entry
//   rd_next_data  - entry that becomes head after a pop; when only one entry
//                   is stored this is wr_data, so a same-edge push can be
//                   presented straight after the pop
//   full, empty   - occupancy flags
//   count         - occupancy, log2(DEPTH)+1 bits
module chara_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rd_data,
  output logic [DATA_W-1:0]      rd_next_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_ptr_nxt;
  logic              do_push;
  logic              do_pop;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign rd_ptr_nxt = rd_ptr + AW'(1);

  assign rd_data      = mem[rd_ptr];
  assign rd_next_data = (count == CW'(1)) ? wr_data : mem[rd_ptr_nxt];

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/chara_feeder.sv
// Splits a byte stream into 4-bit alphabet symbols (high nibble first) for
// the goto/failure lookup, buffering bytes in a small FIFO.
// Ports:
//   CLK, RST               - clock, asynchronous active-high reset
//   EN                     - global enable shared with the matcher; when low
//                            nothing moves and outputs hold
//   BYTE_IN/LAST/VALID     - byte source; BYTE_READY = FIFO not full AND EN
//   CHARA/VALID/LAST       - symbol to the matcher; LAST only on the low
//                            nibble of a byte flagged last
//   CHARA_READY            - matcher consumes the symbol
//   CHARA_CNT              - symbol counter, present only when macro
//                            CHARA_FEEDER_COUNT_EN is defined; clears after
//                            the last symbol of a text
module chara_feeder
  import chara_feeder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [BYTE_W-1:0]  BYTE_IN,
  input  logic               BYTE_LAST,
  input  logic               BYTE_VALID,
  output logic               BYTE_READY,
  output logic [CHARA_W-1:0] CHARA,
  output logic               CHARA_VALID,
  output logic               CHARA_LAST,
  input  logic               CHARA_READY
`ifdef CHARA_FEEDER_COUNT_EN
  ,
  output logic [15:0]        CHARA_CNT
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  feed_state_t        state;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] next_entry;
  logic [ENTRY_W-1:0] src_entry;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               byte_xfer;
  logic               sym_xfer;
  logic               pop;
  logic               more;

  // RST term keeps BYTE_READY low for the whole reset, even with EN high.
  assign BYTE_READY = EN & ~fifo_full & ~RST;
  assign byte_xfer  = BYTE_VALID & BYTE_READY;
  assign sym_xfer   = CHARA_VALID & CHARA_READY & EN;
  assign pop        = sym_xfer & (state == LO);

  // A byte remains after the pop if one was already queued behind the head
  // or one arrives on the same edge.
  assign more = (fifo_count > CNT_W'(1)) | byte_xfer;

  // In LO the next nibble comes from the byte behind the head; otherwise
  // from the head itself.
  assign src_entry = (state == LO) ? next_entry : head_entry;

  chara_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk          (CLK),
    .rst          (RST),
    .push         (byte_xfer),
    .wr_data      ({BYTE_LAST, BYTE_IN}),
    .pop          (pop),
    .rd_data      (head_entry),
    .rd_next_data (next_entry),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count        (fifo_count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      CHARA       <= '0;
      CHARA_VALID <= 1'b0;
      CHARA_LAST  <= 1'b0;
    end else if (EN) begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state       <= HI;
            CHARA       <= src_entry[7:4];
            CHARA_VALID <= 1'b1;
            CHARA_LAST  <= 1'b0;
          end
        end
        HI: begin
          if (CHARA_READY) begin
            state      <= LO;
            CHARA      <= src_entry[3:0];
            CHARA_LAST <= src_entry[8];
          end
        end
        LO: begin
          if (CHARA_READY) begin
            CHARA_LAST <= 1'b0;
            if (more) begin
              state <= HI;
              CHARA <= src_entry[7:4];
            end else begin
              state       <= IDLE;
              CHARA       <= '0;
              CHARA_VALID <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          CHARA       <= '0;
          CHARA_VALID <= 1'b0;
          CHARA_LAST  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHARA_FEEDER_COUNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CHARA_CNT <= '0;
    end else if (sym_xfer) begin
      CHARA_CNT <= CHARA_LAST ? 16'd0 : CHARA_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chara_feeder.sv
module tb_chara_feeder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [7:0] BYTE_IN;
  logic       BYTE_LAST;
  logic       BYTE_VALID;
  logic       BYTE_READY;
  logic [3:0] CHARA;
  logic       CHARA_VALID;
  logic       CHARA_LAST;
  logic       CHARA_READY;
`ifdef CHARA_FEEDER_COUNT_EN
  logic [15:0] CHARA_CNT;
  logic [15:0] exp_cnt = 16'd0;
`endif

  int passed   = 0;
  int total    = 0;
  int sym_seen = 0;
  logic [4:0] exp_q[$];   // {last, nibble} in emission order

  always #5 CLK = ~CLK;

  chara_feeder #(.DEPTH(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .BYTE_IN     (BYTE_IN),
    .BYTE_LAST   (BYTE_LAST),
    .BYTE_VALID  (BYTE_VALID),
    .BYTE_READY  (BYTE_READY),
    .CHARA       (CHARA),
    .CHARA_VALID (CHARA_VALID),
    .CHARA_LAST  (CHARA_LAST),
    .CHARA_READY (CHARA_READY)
`ifdef CHARA_FEEDER_COUNT_EN
    ,
    .CHARA_CNT   (CHARA_CNT)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    BYTE_IN    = b;
    BYTE_LAST  = last;
    BYTE_VALID = 1'b1;
    while (!(BYTE_READY && EN) && n < 50) begin
      tick();
      n++;
    end
    chk("send_accept", {31'd0, BYTE_READY}, 32'd1);
    tick();
    BYTE_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (CHARA_VALID && n < bound) begin
      tick();
      n++;
    end
    chk("drain_idle", {31'd0, CHARA_VALID}, 32'd0);
  endtask

  // Scoreboard: record accepted bytes as two expected symbols, compare each
  // symbol the matcher consumes. Sampled mid-cycle, inputs are settled.
  always @(negedge CLK) begin
    if (!RST && EN && CHARA_VALID && CHARA_READY) begin
      sym_seen++;
      chk("sym_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("sym", {27'd0, CHARA_LAST, CHARA}, {27'd0, exp_q.pop_front()});
`ifdef CHARA_FEEDER_COUNT_EN
      chk("cnt", {16'd0, CHARA_CNT}, {16'd0, exp_cnt});
      exp_cnt = CHARA_LAST ? 16'd0 : exp_cnt + 16'd1;
`endif
    end
    if (!RST && EN && BYTE_VALID && BYTE_READY) begin
      exp_q.push_back({1'b0, BYTE_IN[7:4]});
      exp_q.push_back({BYTE_LAST, BYTE_IN[3:0]});
    end
  end

  initial begin
    int s0;
    logic [3:0] k;

    RST = 1'b1; EN = 1'b1; BYTE_IN = 8'h00; BYTE_LAST = 1'b0;
    BYTE_VALID = 1'b0; CHARA_READY = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_chara", {28'd0, CHARA}, 32'd0);
    chk("rst_valid", {31'd0, CHARA_VALID}, 32'd0);
    chk("rst_last", {31'd0, CHARA_LAST}, 32'd0);
    chk("rst_byte_ready", {31'd0, BYTE_READY}, 32'd0);
    RST = 1'b0;
    tick();
    chk("post_rst_ready", {31'd0, BYTE_READY}, 32'd1);

    // Single byte 0xA5, READY held high
    CHARA_READY = 1'b1;
    send_byte(8'hA5, 1'b1);
    chk("s1_latency", {31'd0, CHARA_VALID}, 32'd0);
    tick();
    chk("s1_hi_valid", {31'd0, CHARA_VALID}, 32'd1);
    chk("s1_hi", {28'd0, CHARA}, 32'hA);
    chk("s1_hi_last", {31'd0, CHARA_LAST}, 32'd0);
    tick();
    chk("s1_lo", {28'd0, CHARA}, 32'h5);
    chk("s1_lo_last", {31'd0, CHARA_LAST}, 32'd1);
    tick();
    chk("s1_idle", {31'd0, CHARA_VALID}, 32'd0);
`ifdef CHARA_FEEDER_COUNT_EN
    chk("s1_cnt_clr", {16'd0, CHARA_CNT}, 32'd0);
`endif

    // Fill to full with READY low, then drain
    s0 = sym_seen;
    CHARA_READY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      k = 4'(i);
      send_byte({k + 4'd1, ~k}, i == 7);
    end
    chk("s2_full_ready", {31'd0, BYTE_READY}, 32'd0);
    BYTE_IN = 8'h9C; BYTE_LAST = 1'b1; BYTE_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("s2_hold_chara", {28'd0, CHARA}, 32'h1);
      chk("s2_hold_valid", {31'd0, CHARA_VALID}, 32'd1);
      chk("s2_hold_ready", {31'd0, BYTE_READY}, 32'd0);
      tick();
    end
    CHARA_READY = 1'b1;
    send_byte(8'h9C, 1'b1);
    wait_idle(60);
    chk("s2_sym_total", 32'(sym_seen - s0), 32'd18);

    // Half-rate push aligned with pops: 0x12, 0x34, 0x56
    send_byte(8'h12, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      BYTE_VALID = (c == 3) || (c == 5);
      BYTE_IN    = (c == 3) ? 8'h34 : 8'h56;
      BYTE_LAST  = (c == 5);
      tick();
      BYTE_VALID = 1'b0;
      chk("s3_occupancy", {31'd0, dut.u_fifo.count <= 1}, 32'd1);
      if (c <= 6) begin
        chk("s3_valid", {31'd0, CHARA_VALID}, 32'd1);
        chk("s3_sym", {28'd0, CHARA}, 32'(c));
      end
    end
    chk("s3_idle", {31'd0, CHARA_VALID}, 32'd0);

    // EN low for 3 cycles while in LO
    send_byte(8'h7E, 1'b1);
    tick();
    tick();
    chk("s4_lo", {28'd0, CHARA}, 32'hE);
    EN = 1'b0; BYTE_IN = 8'h99; BYTE_LAST = 1'b0; BYTE_VALID = 1'b1;
    #1;
    chk("s4_ready_off", {31'd0, BYTE_READY}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s4_hold_chara", {28'd0, CHARA}, 32'hE);
      chk("s4_hold_last", {31'd0, CHARA_LAST}, 32'd1);
      chk("s4_hold_valid", {31'd0, CHARA_VALID}, 32'd1);
      chk("s4_no_pop", {28'd0, dut.u_fifo.count}, 32'd1);
    end
    EN = 1'b1; BYTE_VALID = 1'b0;
    tick();
    chk("s4_resume_done", {31'd0, CHARA_VALID}, 32'd0);

    // Reset mid-text with 3 bytes buffered
    CHARA_READY = 1'b0;
    send_byte(8'h31, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h53, 1'b1);
    CHARA_READY = 1'b1;
    tick();
    CHARA_READY = 1'b0;
    chk("s5_lo", {28'd0, CHARA}, 32'h1);
    RST = 1'b1;
    exp_q.delete();
`ifdef CHARA_FEEDER_COUNT_EN
    exp_cnt = 16'd0;
`endif
    #1;
    chk("s5_rst_chara", {28'd0, CHARA}, 32'd0);
    chk("s5_rst_valid", {31'd0, CHARA_VALID}, 32'd0);
    chk("s5_rst_last", {31'd0, CHARA_LAST}, 32'd0);
    chk("s5_rst_ready", {31'd0, BYTE_READY}, 32'd0);
`ifdef CHARA_FEEDER_COUNT_EN
    chk("s5_rst_cnt", {16'd0, CHARA_CNT}, 32'd0);
`endif
    tick();
    RST = 1'b0;
    CHARA_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5_silent", {31'd0, CHARA_VALID}, 32'd0);
    end
    send_byte(8'hF0, 1'b1);
    tick();
    chk("s5_hi", {28'd0, CHARA}, 32'hF);
    tick();
    chk("s5_lo_new", {28'd0, CHARA}, 32'h0);
    chk("s5_lo_last", {31'd0, CHARA_LAST}, 32'd1);
    tick();
    chk("s5_idle", {31'd0, CHARA_VALID}, 32'd0);

`ifdef CHARA_FEEDER_COUNT_EN
    // Symbol counter over two bytes
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b1);
    chk("s6_cnt0", {16'd0, CHARA_CNT}, 32'd0);
    chk("s6_sym0", {28'd0, CHARA}, 32'hA);
    tick();
    chk("s6_cnt1", {16'd0, CHARA_CNT}, 32'd1);
    tick();
    chk("s6_cnt2", {16'd0, CHARA_CNT}, 32'd2);
    tick();
    chk("s6_cnt3", {16'd0, CHARA_CNT}, 32'd3);
    chk("s6_last", {31'd0, CHARA_LAST}, 32'd1);
    tick();
    chk("s6_cnt_clr", {16'd0, CHARA_CNT}, 32'd0);
    chk("s6_idle", {31'd0, CHARA_VALID}, 32'd0);
`endif

    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
